// File: rtl/vpu_dma_if.sv
// Bus bundle for vpu_dma: CPU register port plus the borrowed VPU register port.
// slave is the DMA side; master is the CPU/VPU system side.
interface vpu_dma_if;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic       busy;
    logic [3:0] vpu_ad;
    logic [7:0] vpu_di;
    logic [7:0] vpu_do;
    logic       vpu_rw;
    logic       vpu_cs;

    modport slave (
        input  AD, DI, rw, cs, vpu_do,
        output DO, irq, busy, vpu_ad, vpu_di, vpu_rw, vpu_cs
    );

    modport master (
        output AD, DI, rw, cs, vpu_do,
        input  DO, irq, busy, vpu_ad, vpu_di, vpu_rw, vpu_cs
    );
endinterface

// File: rtl/vpu_dma.sv
// VRAM fill/copy DMA engine driving the VPU register port one byte at a time,
// with a CPU-visible register file for setup, status and interrupt.
module vpu_dma (
    input  logic     clk,
    input  logic     rst,
    vpu_dma_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, SRC_HI, SRC_LO, RD, GAP_R, DST_HI, DST_LO, WR, GAP1, GAP2, GAP3
    } state_t;

    state_t      state, state_nxt;
    logic [12:0] dst, src, dst_nxt, src_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  fill, data;
    logic        mode, mode_nxt, ien, done, done_set;
    logic        busy, wr_en, rd_en, ctrl_wr, start, abort;
    logic        cs_nxt, rw_nxt;
    logic [3:0]  ad_nxt;
    logic [7:0]  di_nxt;

    assign busy    = (state != IDLE);
    assign wr_en   = bus.cs & ~bus.rw;
    assign rd_en   = bus.cs & bus.rw;
    assign ctrl_wr = wr_en & (bus.AD == 3'd5);
    assign abort   = ctrl_wr & bus.DI[7];
    assign start   = ctrl_wr & bus.DI[0] & ~bus.DI[7] & ~busy;

    always_comb begin
        state_nxt = state;
        dst_nxt   = dst;
        src_nxt   = src;
        cnt_nxt   = cnt;
        done_set  = 1'b0;
        mode_nxt  = (ctrl_wr & ~busy) ? bus.DI[1] : mode;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cnt == '0) done_set  = 1'b1;
                    else           state_nxt = bus.DI[1] ? SRC_HI : DST_HI;
                end
            end
            SRC_HI: state_nxt = SRC_LO;
            SRC_LO: state_nxt = RD;
            RD:     state_nxt = GAP_R;
            GAP_R:  state_nxt = DST_HI;
            DST_HI: state_nxt = DST_LO;
            DST_LO: state_nxt = WR;
            WR:     state_nxt = GAP1;
            GAP1:   state_nxt = GAP2;
            GAP2:   state_nxt = GAP3;
            GAP3: begin
                dst_nxt = dst + 13'd1;
                if (mode) src_nxt = src + 13'd1;
                cnt_nxt = cnt - 16'd1;
                if (cnt == 16'd1) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else begin
                    state_nxt = mode ? SRC_HI : DST_HI;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A completed byte keeps its pointer update; abort only stops the sequence.
        if (abort & busy) begin
            state_nxt = IDLE;
            done_set  = 1'b0;
        end
    end

    // VPU outputs are registered from the state being entered so they hold for the whole clk.
    always_comb begin
        cs_nxt = 1'b0;
        rw_nxt = 1'b0;
        ad_nxt = '0;
        di_nxt = '0;
        case (state_nxt)
            SRC_HI: begin cs_nxt = 1'b1; ad_nxt = 4'd1; di_nxt = {3'b000, src_nxt[12:8]}; end
            SRC_LO: begin cs_nxt = 1'b1; ad_nxt = 4'd2; di_nxt = src_nxt[7:0]; end
            RD:     begin cs_nxt = 1'b1; rw_nxt = 1'b1; end
            DST_HI: begin cs_nxt = 1'b1; ad_nxt = 4'd1; di_nxt = {3'b000, dst_nxt[12:8]}; end
            DST_LO: begin cs_nxt = 1'b1; ad_nxt = 4'd2; di_nxt = dst_nxt[7:0]; end
            WR:     begin cs_nxt = 1'b1; di_nxt = mode_nxt ? data : fill; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dst        <= '0;
            src        <= '0;
            cnt        <= '0;
            fill       <= '0;
            data       <= '0;
            mode       <= 1'b0;
            ien        <= 1'b0;
            done       <= 1'b0;
            bus.vpu_cs <= 1'b0;
            bus.vpu_rw <= 1'b0;
            bus.vpu_ad <= '0;
            bus.vpu_di <= '0;
        end else begin
            state      <= state_nxt;
            dst        <= dst_nxt;
            src        <= src_nxt;
            cnt        <= cnt_nxt;
            mode       <= mode_nxt;
            bus.vpu_cs <= cs_nxt;
            bus.vpu_rw <= rw_nxt;
            bus.vpu_ad <= ad_nxt;
            bus.vpu_di <= di_nxt;
            if (state == RD) data <= bus.vpu_do;
            if (ctrl_wr) ien <= bus.DI[6];
            if (wr_en & ~busy) begin
                case (bus.AD)
                    3'd0: dst[12:8]  <= bus.DI[4:0];
                    3'd1: dst[7:0]   <= bus.DI;
                    3'd2: cnt[15:8]  <= bus.DI;
                    3'd3: cnt[7:0]   <= bus.DI;
                    3'd4: fill       <= bus.DI;
                    3'd6: src[12:8]  <= bus.DI[4:0];
                    3'd7: src[7:0]   <= bus.DI;
                    default: ;
                endcase
            end
            if (done_set)                          done <= 1'b1;
            else if (rd_en && (bus.AD == 3'd5))    done <= 1'b0;
        end
    end

    always_comb begin
        bus.DO = '0;
        case (bus.AD)
            3'd0: bus.DO = {3'b000, dst[12:8]};
            3'd1: bus.DO = dst[7:0];
            3'd2: bus.DO = cnt[15:8];
            3'd3: bus.DO = cnt[7:0];
            3'd4: bus.DO = fill;
            3'd5: bus.DO = {done, ien, 4'b0000, mode, busy};
            3'd6: bus.DO = {3'b000, src[12:8]};
            3'd7: bus.DO = src[7:0];
            default: ;
        endcase
    end

    assign bus.irq  = done & ien;
    assign bus.busy = busy;
endmodule

// File: tb/tb_vpu_dma.sv
// Bench for vpu_dma: a VRAM/VPU model, an expected per-clk bus plan built from
// the transfer rules, and directed register-level scenarios.
module tb_vpu_dma;
    logic clk = 1'b0;
    logic rst;
    vpu_dma_if bus ();

    vpu_dma dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // VPU model: regs 1/2 set the address, reg 0 accesses VRAM and auto-increments.
    logic [7:0]  vram [0:8191];
    logic [12:0] vaddr;
    int          cs_count = 0;
    assign bus.vpu_do = vram[vaddr];
    always @(posedge clk) begin
        if (bus.vpu_cs === 1'b1) begin
            cs_count <= cs_count + 1;
            case (bus.vpu_ad)
                4'd1: vaddr[12:8] <= bus.vpu_di[4:0];
                4'd2: vaddr[7:0]  <= bus.vpu_di;
                4'd0: begin
                    if (bus.vpu_rw == 1'b0) vram[vaddr] <= bus.vpu_di;
                    vaddr <= vaddr + 13'd1;
                end
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic       is_bus;
        logic [3:0] ad;
        logic       rw;
        logic [7:0] di;
        logic       chk_di;
    } ent_t;

    ent_t       q [$];
    logic [7:0] exp_mem [0:8191];
    int         n_checks = 0;
    int         n_err = 0;
    int         busy_cnt = 0;
    logic       chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_bus(input logic [3:0] ad, input logic rw, input logic [7:0] di, input logic chk);
        q.push_back('{is_bus: 1'b1, ad: ad, rw: rw, di: di, chk_di: chk});
    endfunction

    function automatic void push_gap(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) q.push_back('{is_bus: 1'b0, ad: 4'd0, rw: 1'b0, di: 8'd0, chk_di: 1'b0});
    endfunction

    // Expected VPU traffic for a whole transfer, one entry per busy clk.
    task automatic plan(input bit copy, input logic [12:0] s0, input logic [12:0] d0,
                        input int unsigned n, input logic [7:0] f, input bit upd);
        logic [12:0] s, d;
        logic [7:0]  b;
        s = s0;
        d = d0;
        for (int unsigned i = 0; i < n; i++) begin
            if (copy) begin
                push_bus(4'd1, 1'b0, {3'b000, s[12:8]}, 1'b1);
                push_bus(4'd2, 1'b0, s[7:0], 1'b1);
                push_bus(4'd0, 1'b1, 8'h00, 1'b0);
                push_gap(1);
            end
            b = copy ? exp_mem[s] : f;
            push_bus(4'd1, 1'b0, {3'b000, d[12:8]}, 1'b1);
            push_bus(4'd2, 1'b0, d[7:0], 1'b1);
            push_bus(4'd0, 1'b0, b, 1'b1);
            push_gap(3);
            if (upd) exp_mem[d] = b;
            d = d + 13'd1;
            s = s + 13'd1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [14:0] act, exp, msk;
            ent_t e;
            act = {bus.busy, bus.vpu_cs, bus.vpu_ad, bus.vpu_rw, bus.vpu_di};
            if (bus.busy === 1'b1) busy_cnt++;
            if (q.size() == 0) begin
                exp = '0;
                msk = 15'h6000;
            end else begin
                e   = q.pop_front();
                exp = {1'b1, e.is_bus, e.ad, e.rw, e.di};
                msk = e.is_bus ? (e.chk_di ? 15'h7FFF : 15'h7F00) : 15'h6000;
            end
            check("bus_cycle", {17'd0, act & msk}, {17'd0, exp & msk});
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        bus.AD = a; bus.DI = d; bus.rw = 1'b0; bus.cs = 1'b1;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        bus.AD = a; bus.rw = 1'b1; bus.cs = 1'b1;
        #1 d = bus.DO;
        @(posedge clk); #1;
        bus.cs = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        cpu_read(a, d);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_done_timeout", {31'd0, n >= 500}, 32'd0);
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int nbad;
        int cs_base;
        rst = 1'b1; bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = '0; bus.DI = '0;
        vaddr <= '0;
        for (int i = 0; i < 8192; i++) begin
            vram[i] <= 8'h00;
            exp_mem[i] = 8'h00;
        end
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("reset_outputs", {26'd0, bus.busy, bus.vpu_cs, bus.vpu_rw, bus.irq, |bus.vpu_ad, |bus.vpu_di}, 32'd0);
        for (int i = 0; i < 8; i++) read_chk("reset_reg", i[2:0], 8'h00);

        // Fill 4 bytes at 0x0100
        cpu_write(3'd0, 8'hE1);
        read_chk("dst_hi_unused_bits", 3'd0, 8'h01);
        cpu_write(3'd1, 8'h00); cpu_write(3'd2, 8'h00); cpu_write(3'd3, 8'h04); cpu_write(3'd4, 8'h5A);
        busy_cnt = 0;
        cpu_write(3'd5, 8'h41);
        plan(1'b0, 13'h0000, 13'h0100, 4, 8'h5A, 1'b1);
        wait_done();
        check("fill_busy_clks", busy_cnt, 24);
        check("fill_irq", {31'd0, bus.irq}, 32'd1);
        check("fill_vram", {vram[13'h100], vram[13'h101], vram[13'h102], vram[13'h103]}, 32'h5A5A5A5A);
        read_chk("fill_ctrl", 3'd5, 8'hC0);
        check("fill_irq_cleared", {31'd0, bus.irq}, 32'd0);
        read_chk("fill_dst_lo", 3'd1, 8'h04);
        read_chk("fill_cnt_lo", 3'd3, 8'h00);

        // Copy 3 bytes 0x0000 -> 0x0800
        vram[0] <= 8'h11; vram[1] <= 8'h22; vram[2] <= 8'h33;
        exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33;
        cpu_write(3'd6, 8'h00); cpu_write(3'd7, 8'h00);
        cpu_write(3'd0, 8'h08); cpu_write(3'd1, 8'h00); cpu_write(3'd3, 8'h03);
        busy_cnt = 0;
        cpu_write(3'd5, 8'h43);
        plan(1'b1, 13'h0000, 13'h0800, 3, 8'h00, 1'b1);
        wait_done();
        check("copy_busy_clks", busy_cnt, 30);
        check("copy_vram", {8'd0, vram[13'h800], vram[13'h801], vram[13'h802]}, 32'h00112233);
        read_chk("copy_ctrl", 3'd5, 8'hC2);
        read_chk("copy_src_lo", 3'd7, 8'h03);
        read_chk("copy_dst_hi", 3'd0, 8'h08);
        read_chk("copy_dst_lo", 3'd1, 8'h03);

        // Address wrap at 0x1FFF
        cpu_write(3'd0, 8'h1F); cpu_write(3'd1, 8'hFF); cpu_write(3'd3, 8'h02); cpu_write(3'd4, 8'h77);
        cpu_write(3'd5, 8'h01);
        plan(1'b0, 13'h0000, 13'h1FFF, 2, 8'h77, 1'b1);
        wait_done();
        check("wrap_vram", {16'd0, vram[13'h1FFF], vram[13'h0000]}, 32'h7777);
        check("wrap_irq_masked", {31'd0, bus.irq}, 32'd0);
        read_chk("wrap_dst_hi", 3'd0, 8'h00);
        read_chk("wrap_dst_lo", 3'd1, 8'h01);
        read_chk("wrap_ctrl", 3'd5, 8'h80);

        // START with CNT = 0
        cs_base = cs_count;
        cpu_write(3'd5, 8'h01);
        read_chk("cnt0_done_next_clk", 3'd5, 8'h80);
        read_chk("cnt0_done_cleared", 3'd5, 8'h00);
        cyc(3);
        check("cnt0_no_vpu_cycles", cs_count - cs_base, 0);

        // ABORT on the 8th busy clk of a 4-byte fill
        cpu_write(3'd0, 8'h02); cpu_write(3'd1, 8'h00); cpu_write(3'd3, 8'h04); cpu_write(3'd4, 8'hA5);
        cpu_write(3'd5, 8'h01);
        plan(1'b0, 13'h0000, 13'h0200, 4, 8'hA5, 1'b0);
        exp_mem[13'h200] = 8'hA5;
        cyc(7);
        cpu_write(3'd5, 8'h80);
        q.delete();
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_vram", {16'd0, vram[13'h200], vram[13'h201]}, 32'h0000A500);
        read_chk("abort_ctrl", 3'd5, 8'h00);
        read_chk("abort_cnt_lo", 3'd3, 8'h03);
        read_chk("abort_dst_lo", 3'd1, 8'h01);

        // START and ABORT together: nothing starts, DONE stays clear
        cpu_write(3'd5, 8'h81);
        cyc(2);
        read_chk("start_abort_ctrl", 3'd5, 8'h00);

        // rst during the RD clk of a copy
        cpu_write(3'd6, 8'h00); cpu_write(3'd7, 8'h00);
        cpu_write(3'd0, 8'h09); cpu_write(3'd1, 8'h00); cpu_write(3'd3, 8'h03);
        cpu_write(3'd5, 8'h43);
        plan(1'b1, 13'h0000, 13'h0900, 3, 8'h00, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        q.delete();
        check("rst_mid_outputs", {28'd0, bus.vpu_cs, bus.busy, bus.irq, bus.vpu_rw}, 32'd0);
        for (int i = 0; i < 8; i++) read_chk("rst_mid_reg", i[2:0], 8'h00);
        check("rst_mid_vram", {24'd0, vram[13'h900]}, 32'd0);

        // Whole VRAM image against the model
        cyc(2);
        nbad = 0;
        for (int i = 0; i < 8192; i++) if (vram[i] !== exp_mem[i]) nbad++;
        check("vram_image", nbad, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/vpu_dma.md
VPU_DMA -- requirements
Module: vpu_dma

Interface
REQ-001 clk  in  1  system clock; same clock as the VPU register port.
REQ-002 rst  in  1  reset: rst, synchronous, active-high; clock clk.
REQ-003 AD  in  3  CPU register select.
REQ-004 DI  in  8  CPU write data.
REQ-005 DO  out  8  CPU read data; combinational mux of registers.
REQ-006 rw  in  1  1 = CPU read, 0 = CPU write.
REQ-007 cs  in  1  CPU chip select.
REQ-008 irq  out  1  level interrupt, equal to DONE & IEN.
REQ-009 busy  out  1  high while a transfer runs; the external mux grants the VPU port to vpu_dma when high.
REQ-010 vpu_ad  out  4  VPU register select.
REQ-011 vpu_di  out  8  data to the VPU.
REQ-012 vpu_do  in  8  data from the VPU.
REQ-013 vpu_rw  out  1  VPU read/write.
REQ-014 vpu_cs  out  1  VPU chip select.

Function
REQ-015 CPU register map: 0 DST[12:8]; 1 DST[7:0]; 2 CNT[15:8]; 3 CNT[7:0]; 4 FILL; 5 CTRL; 6 SRC[12:8]; 7 SRC[7:0].
REQ-016 CPU writes take effect at the clk posedge with cs & !rw; unused DI bits are ignored; reads of address registers return {3'b000, addr}.
REQ-017 CTRL write bits: bit0 START (self-clearing); bit1 MODE (0 = fill, 1 = copy); bit6 IEN; bit7 ABORT (self-clearing).
REQ-018 CTRL read value: {DONE, IEN, 4'b0000, MODE, busy}; a CPU read of CTRL clears DONE at that posedge.
REQ-019 While busy, CPU writes to registers 0-4 and 6-7, and START, are ignored; only ABORT and IEN are accepted.
REQ-020 FSM states: IDLE, SRC_HI, SRC_LO, RD, GAP_R, DST_HI, DST_LO, WR, GAP1, GAP2, GAP3.
REQ-021 START in IDLE with CNT = 0: stay IDLE and set DONE on the next clk; no VPU cycles are issued.
REQ-022 START in IDLE with CNT != 0: busy goes high on the next clk; copy enters SRC_HI, fill enters DST_HI.
REQ-023 Every bus state (SRC_HI, SRC_LO, RD, DST_HI, DST_LO, WR) drives vpu_cs = 1 for exactly one clk.
REQ-024 During a bus state, vpu_ad, vpu_rw and vpu_di are registered and stable for that whole clk.
REQ-025 vpu_cs = 0 in every GAP state and in IDLE.
REQ-026 SRC_HI writes VPU reg 1 with {3'b000, SRC[12:8]}; SRC_LO writes VPU reg 2 with SRC[7:0].
REQ-027 RD: VPU reg 0 read with vpu_rw = 1; vpu_do is latched into the internal byte at the end of the clk.
REQ-028 GAP_R is a single idle clk that absorbs the VPU read auto-increment.
REQ-029 DST_HI and DST_LO write VPU regs 1 and 2 with DST; WR writes VPU reg 0 with the copied byte (copy) or FILL (fill).
REQ-030 GAP1-GAP3 are three idle clks that absorb the VPU write auto-increment before the next address write.
REQ-031 Leaving GAP3: DST += 1, SRC += 1 (copy only), CNT -= 1.
REQ-032 After GAP3: if the new CNT = 0, go to IDLE, drop busy and set DONE; otherwise start the next byte.
REQ-033 Addresses are 13-bit and wrap 0x1FFF -> 0x0000; the VPU AUT, ID and AutoOffset settings do not affect results.
REQ-034 Cost per byte: fill 6 clks (DST_HI, DST_LO, WR, GAP1-3); copy 10 clks.
REQ-035 Per-byte pass/fail: at GAP3 exit, the addressed VRAM byte holds FILL (fill) or the byte read at SRC (copy).
REQ-036 ABORT while busy: next clk enters IDLE with busy = 0 and vpu_cs = 0, DONE unchanged.
REQ-037 After ABORT, DST, SRC and CNT hold their progress values.
REQ-038 START and ABORT in the same write: ABORT wins, and no transfer starts.
REQ-039 A DONE set and a CTRL read in the same clk: DONE ends set.

Reset
REQ-040 On rst: state IDLE; busy, vpu_cs, vpu_rw, irq and DONE = 0.
REQ-041 On rst: vpu_ad = 0, vpu_di = 0; all CPU registers = 0, including IEN and MODE.
REQ-042 rst mid-transfer terminates it within the same clk edge, with no further VPU cycles.

Verification
REQ-043 Fill: DST = 0x0100, CNT = 4, FILL = 0x5A, IEN = 1, START -> busy for 24 clks; VRAM 0x0100-0x0103 = 0x5A; DONE = 1, irq = 1; reading CTRL returns 0xC0 and clears irq.
REQ-044 Copy: SRC = 0x0000 preloaded 11,22,33; DST = 0x0800; CNT = 3; MODE = 1 -> busy 30 clks; VRAM 0x0800-0x0802 = 11,22,33.
REQ-045 Wrap: fill with DST = 0x1FFF, CNT = 2 -> bytes written at 0x1FFF and 0x0000; DST reads back 0x0001.
REQ-046 CNT = 0 plus START -> vpu_cs never asserts; DONE = 1 one clk later.
REQ-047 ABORT on the 8th clk of a 4-byte fill -> exactly 1 byte written; busy = 0 next clk; DONE = 0; CNT reads 3.
REQ-048 rst asserted mid-copy -> vpu_cs = 0 immediately; all registers read 0.
